// File: rtl/contador_varredura_prog.sv
// contador_varredura_prog: sweep counter with runtime limits, step size and four sweep modes.
// Drives position flags, a registered turnaround pulse and a sticky one-shot done flag.
module contador_varredura_prog #(
    parameter int N = 6,
    parameter int S = 3
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         conta,
    input  logic         carrega,
    input  logic [N-1:0] valor,
    input  logic [N-1:0] lim_min,
    input  logic [N-1:0] lim_max,
    input  logic [S-1:0] passo,
    input  logic [1:0]   modo,
    output logic [N-1:0] Q,
    output logic         direcao,
    output logic         inicio,
    output logic         fim,
    output logic         meio,
    output logic         volta,
    output logic         parado,
    output logic         erro
);

    typedef enum logic [1:0] {
        MODO_PINGPONG = 2'b00,
        MODO_SOBE     = 2'b01,
        MODO_DESCE    = 2'b10,
        MODO_UNICO    = 2'b11
    } modo_t;

    logic [N-1:0] r_q;
    logic         r_direcao;
    logic         r_volta;
    logic         r_parado;

    logic [N:0]   w_q_ext;
    logic [N:0]   w_min_ext;
    logic [N:0]   w_max_ext;
    logic [N:0]   w_passo_ext;
    logic [N:0]   w_meio_ext;
    logic [N-1:0] w_carga;
    logic [N-1:0] w_sobe;
    logic [N-1:0] w_desce;
    logic [N-1:0] w_vira_baixo;
    logic [N-1:0] w_vira_cima;
    logic [N-1:0] w_q_next;
    logic         w_dir_next;
    logic         w_volta_next;
    logic         w_parado_next;
    logic         w_erro;
    logic         w_aceita;
    modo_t        w_modo;

    // min(base + inc, teto), evaluated one bit wider so the sum never wraps
    function automatic logic [N-1:0] sat_soma(input logic [N:0] base, input logic [N:0] inc,
                                              input logic [N:0] teto);
        logic [N:0] s;
        s = base + inc;
        return (s > teto) ? teto[N-1:0] : s[N-1:0];
    endfunction

    // max(base - dec, piso) without ever forming a negative difference
    function automatic logic [N-1:0] sat_sub(input logic [N:0] base, input logic [N:0] dec,
                                             input logic [N:0] piso);
        return (base < piso + dec) ? piso[N-1:0] : N'(base - dec);
    endfunction

    assign w_q_ext     = {1'b0, r_q};
    assign w_min_ext   = {1'b0, lim_min};
    assign w_max_ext   = {1'b0, lim_max};
    assign w_passo_ext = (N+1)'(passo);
    assign w_meio_ext  = (w_min_ext + w_max_ext) >> 1;
    assign w_modo      = modo_t'(modo);

    assign w_erro   = (lim_min > lim_max);
    assign w_aceita = conta && !w_erro && (passo != '0) && !r_parado;
    assign w_carga  = (valor < lim_min) ? lim_min : ((valor > lim_max) ? lim_max : valor);

    assign w_sobe       = sat_soma(w_q_ext, w_passo_ext, w_max_ext);
    assign w_desce      = sat_sub(w_q_ext, w_passo_ext, w_min_ext);
    assign w_vira_baixo = sat_sub(w_max_ext, w_passo_ext, w_min_ext);
    assign w_vira_cima  = sat_soma(w_min_ext, w_passo_ext, w_max_ext);

    always_comb begin
        w_q_next      = r_q;
        w_dir_next    = r_direcao;
        w_volta_next  = 1'b0;
        w_parado_next = r_parado;
        if (carrega) begin
            w_q_next      = w_carga;
            w_dir_next    = (w_modo == MODO_DESCE);
            w_parado_next = 1'b0;
        end else if (w_aceita) begin
            // limits moved under Q: snap back without touching direction or volta
            if (w_q_ext < w_min_ext) begin
                w_q_next = lim_min;
            end else if (w_q_ext > w_max_ext) begin
                w_q_next = lim_max;
            end else begin
                case (w_modo)
                    MODO_PINGPONG: begin
                        if (!r_direcao) begin
                            if (r_q == lim_max) begin
                                w_q_next     = w_vira_baixo;
                                w_dir_next   = 1'b1;
                                w_volta_next = 1'b1;
                            end else begin
                                w_q_next = w_sobe;
                            end
                        end else begin
                            if (r_q == lim_min) begin
                                w_q_next     = w_vira_cima;
                                w_dir_next   = 1'b0;
                                w_volta_next = 1'b1;
                            end else begin
                                w_q_next = w_desce;
                            end
                        end
                    end
                    MODO_SOBE: begin
                        w_dir_next = 1'b0;
                        if (r_q == lim_max) begin
                            w_q_next     = lim_min;
                            w_volta_next = 1'b1;
                        end else begin
                            w_q_next = w_sobe;
                        end
                    end
                    MODO_DESCE: begin
                        w_dir_next = 1'b1;
                        if (r_q == lim_min) begin
                            w_q_next     = lim_max;
                            w_volta_next = 1'b1;
                        end else begin
                            w_q_next = w_desce;
                        end
                    end
                    MODO_UNICO: begin
                        w_dir_next = 1'b0;
                        w_q_next   = w_sobe;
                        if (w_sobe == lim_max) begin
                            w_parado_next = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (zera_s) begin
            r_q       <= w_erro ? '0 : lim_min;
            r_direcao <= 1'b0;
            r_volta   <= 1'b0;
            r_parado  <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_direcao <= w_dir_next;
            r_volta   <= w_volta_next;
            r_parado  <= w_parado_next;
        end
    end

    assign Q       = r_q;
    assign direcao = r_direcao;
    assign volta   = r_volta;
    assign parado  = r_parado;
    assign erro    = w_erro;
    assign inicio  = (r_q == lim_min);
    assign fim     = (r_q == lim_max);
    assign meio    = (w_q_ext == w_meio_ext);

endmodule

// File: tb/tb_contador_varredura_prog.sv
// Bench for contador_varredura_prog: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an integer model of the sweep rules.
module tb_contador_varredura_prog;

    localparam int N = 6;
    localparam int S = 3;

    logic         clock = 1'b0;
    logic         zera_s = 1'b0;
    logic         conta = 1'b0;
    logic         carrega = 1'b0;
    logic [N-1:0] valor = '0;
    logic [N-1:0] lim_min = '0;
    logic [N-1:0] lim_max = '0;
    logic [S-1:0] passo = '0;
    logic [1:0]   modo = '0;
    logic [N-1:0] Q;
    logic         direcao, inicio, fim, meio, volta, parado, erro;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    int m_q = 0;
    int m_d = 0;
    int m_v = 0;
    int m_p = 0;

    contador_varredura_prog #(.N(N), .S(S)) dut (
        .clock(clock), .zera_s(zera_s), .conta(conta), .carrega(carrega),
        .valor(valor), .lim_min(lim_min), .lim_max(lim_max), .passo(passo),
        .modo(modo), .Q(Q), .direcao(direcao), .inicio(inicio), .fim(fim),
        .meio(meio), .volta(volta), .parado(parado), .erro(erro)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Apply one clock edge; the model's next state is derived from the inputs present now.
    task automatic tick();
        int q, lmn, lmx, p, nq, nd, nv, np;
        q = m_q; lmn = int'(lim_min); lmx = int'(lim_max); p = int'(passo);
        nq = m_q; nd = m_d; nv = 0; np = m_p;
        if (zera_s) begin
            nq = (lmn > lmx) ? 0 : lmn; nd = 0; np = 0;
        end else if (carrega) begin
            nq = imin(imax(int'(valor), lmn), lmx);
            if (int'(valor) < lmn) nq = lmn;
            else if (int'(valor) > lmx) nq = lmx;
            else nq = int'(valor);
            nd = (modo == 2'b10) ? 1 : 0; np = 0;
        end else if (conta && lmn <= lmx && p != 0 && m_p == 0) begin
            if (q < lmn) nq = lmn;
            else if (q > lmx) nq = lmx;
            else begin
                case (int'(modo))
                    0: begin
                        if (m_d == 0) begin
                            if (q == lmx) begin nq = imax(lmn, lmx - p); nd = 1; nv = 1; end
                            else nq = imin(q + p, lmx);
                        end else begin
                            if (q == lmn) begin nq = imin(lmx, lmn + p); nd = 0; nv = 1; end
                            else nq = imax(q - p, lmn);
                        end
                    end
                    1: begin
                        nd = 0;
                        if (q == lmx) begin nq = lmn; nv = 1; end
                        else nq = imin(q + p, lmx);
                    end
                    2: begin
                        nd = 1;
                        if (q == lmn) begin nq = lmx; nv = 1; end
                        else nq = imax(q - p, lmn);
                    end
                    default: begin
                        nd = 0;
                        nq = imin(q + p, lmx);
                        if (nq == lmx) np = 1;
                    end
                endcase
            end
        end
        @(posedge clock);
        #1;
        m_q = nq; m_d = nd; m_v = nv; m_p = np;
    endtask

    task automatic cfg(input int lmn, input int lmx, input int p, input int md);
        lim_min = N'(lmn);
        lim_max = N'(lmx);
        passo   = S'(p);
        modo    = 2'(md);
    endtask

    task automatic reset_pulse();
        zera_s = 1'b1; tick(); zera_s = 1'b0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("Q", Q, m_q);
            chk("direcao", direcao, m_d);
            chk("volta", volta, m_v);
            chk("parado", parado, m_p);
            chk("erro", erro, lim_min > lim_max);
            chk("inicio", inicio, m_q == int'(lim_min));
            chk("fim", fim, m_q == int'(lim_max));
            chk("meio", meio, m_q == (int'(lim_min) + int'(lim_max)) / 2);
        end
    end

    int pp_seq[12] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4};
    int cl_seq[7]  = '{5, 8, 10, 7, 4, 2, 5};
    int up_seq[4]  = '{3, 5, 1, 3};
    int dn_seq[3]  = '{3, 1, 5};

    initial begin
        // reset state
        cfg(0, 4, 1, 0);
        reset_pulse();
        chk("rst_Q", Q, 0);
        chk("rst_direcao", direcao, 0);
        chk("rst_volta", volta, 0);
        chk("rst_parado", parado, 0);
        chk("rst_inicio", inicio, 1);
        chk_en = 1'b1;

        // ping-pong 0..4 step 1
        conta = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("pp_Q", Q, pp_seq[i]);
            chk("pp_volta", volta, (i == 4 || i == 8));
            chk("pp_meio", meio, pp_seq[i] == 2);
        end
        conta = 1'b0;

        // ping-pong with clamping at both limits
        cfg(2, 10, 3, 0);
        reset_pulse();
        conta = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("clamp_Q", Q, cl_seq[i]);
        end
        conta = 1'b0;

        // wrap-up then wrap-down
        cfg(1, 5, 2, 1);
        reset_pulse();
        conta = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("up_Q", Q, up_seq[i]);
            chk("up_volta", volta, i == 2);
        end
        conta = 1'b0;
        modo = 2'b10; carrega = 1'b1; valor = 6'd5;
        tick();
        carrega = 1'b0;
        chk("dn_load_Q", Q, 5);
        chk("dn_load_dir", direcao, 1);
        conta = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dn_Q", Q, dn_seq[i]);
            chk("dn_volta", volta, i == 2);
        end
        conta = 1'b0;

        // one-shot
        cfg(0, 6, 4, 3);
        reset_pulse();
        conta = 1'b1;
        tick(); chk("os_Q1", Q, 4); chk("os_parado1", parado, 0);
        tick(); chk("os_Q2", Q, 6); chk("os_parado2", parado, 1);
        tick(); chk("os_Q3", Q, 6); chk("os_parado3", parado, 1);
        conta = 1'b0; carrega = 1'b1; valor = 6'd0;
        tick(); carrega = 1'b0;
        chk("os_load_Q", Q, 0); chk("os_load_parado", parado, 0);

        // priority, clamp on load, erro, limits moved under Q
        cfg(0, 10, 1, 0);
        zera_s = 1'b1; carrega = 1'b1; conta = 1'b1; valor = 6'd7;
        tick();
        zera_s = 1'b0; carrega = 1'b0; conta = 1'b0;
        chk("prio_Q", Q, 0); chk("prio_dir", direcao, 0);
        carrega = 1'b1; valor = 6'd60;
        tick(); carrega = 1'b0;
        chk("load_clamp_Q", Q, 10);
        cfg(7, 3, 1, 0);
        #1 chk("erro_flag", erro, 1);
        conta = 1'b1;
        tick();
        chk("erro_hold_Q", Q, 10);
        cfg(0, 6, 1, 0);
        tick();
        conta = 1'b0;
        chk("oor_Q", Q, 6); chk("oor_volta", volta, 0); chk("oor_dir", direcao, 0);

        // degenerate range: position fixed, direction still toggles
        cfg(9, 9, 2, 0);
        reset_pulse();
        conta = 1'b1;
        tick(); chk("eq_Q", Q, 9); chk("eq_dir1", direcao, 1); chk("eq_volta1", volta, 1);
        tick(); chk("eq_dir2", direcao, 0); chk("eq_volta2", volta, 1);
        chk("eq_flags", {inicio, fim, meio}, 3'b111);
        conta = 1'b0;

        // reset mid-sweep while descending
        cfg(0, 4, 1, 0);
        reset_pulse();
        conta = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_Q", Q, 3); chk("mid_dir", direcao, 1);
        zera_s = 1'b1;
        tick();
        zera_s = 1'b0;
        chk("mid_rst_Q", Q, 0); chk("mid_rst_dir", direcao, 0); chk("mid_rst_volta", volta, 0);
        conta = 1'b0;

        // randomized traffic
        cfg(3, 40, 3, 0);
        for (int i = 0; i < 4000; i++) begin
            zera_s  = ($urandom_range(0, 99) < 2);
            carrega = ($urandom_range(0, 99) < 5);
            conta   = ($urandom_range(0, 99) < 75);
            valor   = N'($urandom_range(0, 63));
            if ($urandom_range(0, 99) < 6) begin
                int a, b;
                a = $urandom_range(0, 63);
                b = $urandom_range(0, 63);
                if ($urandom_range(0, 99) < 15) b = a;
                if ($urandom_range(0, 99) < 85 && a > b) begin
                    int t; t = a; a = b; b = t;
                end
                lim_min = N'(a);
                lim_max = N'(b);
            end
            if ($urandom_range(0, 99) < 10) passo = S'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 5)  modo  = 2'($urandom_range(0, 3));
            tick();
        end

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
